rand_gate_scheduler: RTL and testbench
======================================

// Module: rand_gate_scheduler
// PURPOSE
//  Synthesizable scheduler that drives a randomized on/off gate for stalling a
//  stream channel (valid/ready throttling) in hardware test harnesses. OFF and ON
//  phase lengths are drawn from runtime-programmable [min,max] windows by a 16-bit LFSR.
//  Sits between a config master and the throttled channel; start/stop sequence it.
// PARAMETERS
//  CNT_W       8        width of phase-length config regs and phase counter
//  SEED        16'hACE1 LFSR reset value; 0 is replaced by 16'h0001
//  DEF_OFF_MIN 10       reset value of OFF_MIN reg
//  DEF_OFF_MAX 20       reset value of OFF_MAX reg
//  DEF_ON_MIN  30       reset value of ON_MIN reg
//  DEF_ON_MAX  40       reset value of ON_MAX reg
//  DONE_W      16       width of completed-ON-phase counter
// PORTS
//  clk_i        in  1       single clock, all logic on rising edge
//  a_rst_i      in  1       reset, asynchronous, active-high
//  cfg_we_i     in  1       config write strobe
//  cfg_addr_i   in  2       0 OFF_MIN, 1 OFF_MAX, 2 ON_MIN, 3 ON_MAX
//  cfg_data_i   in  CNT_W   config write data
//  cfg_err_o    out 1       1 when OFF_MIN>OFF_MAX or ON_MIN>ON_MAX
//  start_i      in  1       start request (sampled in IDLE only)
//  stop_i       in  1       stop request (graceful)
//  busy_o       out 1       1 in OFF or ON state
//  gate_o       out 1       gate to channel: 1 = pass, 0 = stall
//  on_done_o    out DONE_W  count of completed ON phases, saturating
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): state IDLE, gate_o=0, busy_o=0,
//   on_done_o=0, cfg_err_o=0, cfg regs=DEF_*, LFSR=SEED, stop pending flag=0.
//  LFSR: Galois, x^16+x^14+x^13+x^11+1, advances every cycle out of reset.
//  Draw: span=max-min; d=min+((lfsr[CNT_W-1:0]*(span+1))>>CNT_W), CNT_W+1-bit math,
//   no overflow; d==0 forced to 1. Cfg regs sampled at the draw cycle only.
//  cfg writes accepted in any state; cfg_err_o registered, valid cycle after write.
//  FSM:
//   IDLE: gate_o=0. start_i&!stop_i&!cfg_err_o -> draw OFF d, go OFF next cycle.
//         start_i with cfg_err_o=1, or start_i&stop_i together: ignored, stay IDLE.
//   OFF:  gate_o=0 for exactly d cycles; then draw ON d, go ON.
//         stop_i or pending stop in OFF -> IDLE next cycle (OFF cut short).
//   ON:   gate_o=1 for exactly d consecutive cycles; at last cycle on_done_o+=1
//         (saturate at all-ones); then if stop pending -> IDLE, else draw OFF, go OFF.
//         stop_i in ON sets pending flag; ON phase always completes in full.
//  Latency: start_i at cycle T -> busy_o=1 at T+1, first gate_o=1 at T+1+d_off.
//  gate_o, busy_o registered, glitch-free; gate never toggles within a phase.
//  cfg_err_o rising mid-run: current phase completes, next draw uses regs as-is
//   with span clamped to 0 (d=min); run continues until stop.
//  start_i while busy: ignored. Pending stop cleared on entry to IDLE.
//  Reset mid-phase: gate_o=0 immediately (asynchronous), all state as above.
// TESTING
//  T1 OFF=3..3, ON=5..5, start -> gate period 8: 3 low, 5 high, repeating; on_done +1 per 8.
//  T2 defaults 10..20/30..40, 1000 phases -> every OFF in [10,20], every ON in [30,40].
//  T3 write OFF_MIN=5, OFF_MAX=4 -> cfg_err_o=1 next cycle; start ignored, busy_o stays 0.
//  T4 ON=5..5, stop_i on 2nd high cycle -> 3 more high cycles, then gate_o=0, busy_o=0.
//  T5 OFF_MIN=OFF_MAX=0 -> OFF lasts exactly 1 cycle; start&stop same cycle -> stays IDLE.
//  T6 a_rst_i asserted mid-ON -> gate_o=0 same cycle, on_done_o=0, cfg regs = defaults.

Source files
------------

// File: rtl/rand_gate_scheduler_if.sv
// Config, start/stop and gate bundle between a config master and the gate scheduler.
// Latency: wires only, no storage.
// Backpressure: none; the gate output is itself the throttle applied to the channel.
interface rand_gate_scheduler_if #(
    parameter int CNT_W  = 8,
    parameter int DONE_W = 16
);
    logic              cfg_we_i;
    logic [1:0]        cfg_addr_i;
    logic [CNT_W-1:0]  cfg_data_i;
    logic              cfg_err_o;
    logic              start_i;
    logic              stop_i;
    logic              busy_o;
    logic              gate_o;
    logic [DONE_W-1:0] on_done_o;

    // Config master side: drives writes and start/stop, observes status
    modport master (
        output cfg_we_i, cfg_addr_i, cfg_data_i, start_i, stop_i,
        input  cfg_err_o, busy_o, gate_o, on_done_o
    );

    // Scheduler side
    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_data_i, start_i, stop_i,
        output cfg_err_o, busy_o, gate_o, on_done_o
    );
endinterface

// File: rtl/rand_gate_scheduler.sv
// Randomized on/off gate generator: OFF/ON phase lengths drawn by a 16-bit LFSR from programmable windows.
// Latency: start -> busy next cycle, first pass cycle after d_off OFF cycles; all outputs registered.
// Backpressure: none accepted; stop is graceful (OFF cut short, ON always runs to completion).
module rand_gate_scheduler #(
    parameter int          CNT_W       = 8,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          DEF_OFF_MIN = 10,
    parameter int          DEF_OFF_MAX = 20,
    parameter int          DEF_ON_MIN  = 30,
    parameter int          DEF_ON_MAX  = 40,
    parameter int          DONE_W      = 16
) (
    input logic                 clk_i,
    input logic                 a_rst_i,
    rand_gate_scheduler_if.slave bus
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    // Feedback mask for x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OFF  = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               gate_q, gate_d;
    logic               busy_q, busy_d;
    logic               pend_q, pend_d;
    logic               err_q, err_d;
    logic [DONE_W-1:0]  done_q, done_d;
    logic [CNT_W-1:0]   off_min_q, off_min_d;
    logic [CNT_W-1:0]   off_max_q, off_max_d;
    logic [CNT_W-1:0]   on_min_q, on_min_d;
    logic [CNT_W-1:0]   on_max_q, on_max_d;
    logic [CNT_W-1:0]   d_off;
    logic [CNT_W-1:0]   d_on;
    logic               stop_now;

    // Scale the low LFSR bits into [mn, mx]; an inverted window collapses to mn.
    function automatic logic [CNT_W-1:0] draw_len(
        input logic [CNT_W-1:0] mn,
        input logic [CNT_W-1:0] mx,
        input logic [CNT_W-1:0] r
    );
        logic [CNT_W:0]   span1;
        logic [2*CNT_W:0] prod;
        logic [CNT_W-1:0] d;
        span1 = (mn > mx) ? (CNT_W+1)'(1) : ({1'b0, mx} - {1'b0, mn} + (CNT_W+1)'(1));
        prod  = {{(CNT_W+1){1'b0}}, r} * {{CNT_W{1'b0}}, span1};
        // The scaled offset never exceeds span, so mn + offset stays within CNT_W bits.
        d     = mn + prod[2*CNT_W-1:CNT_W];
        if (d == '0) begin
            d = CNT_W'(1);
        end
        return d;
    endfunction

    // Free-running LFSR step and the two candidate phase lengths for this cycle
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        d_off  = draw_len(off_min_q, off_max_q, lfsr_q[CNT_W-1:0]);
        d_on   = draw_len(on_min_q, on_max_q, lfsr_q[CNT_W-1:0]);
    end

    // Config register writes (any state) and the window-error flag derived from the new values
    always_comb begin
        off_min_d = off_min_q;
        off_max_d = off_max_q;
        on_min_d  = on_min_q;
        on_max_d  = on_max_q;
        if (bus.cfg_we_i) begin
            case (bus.cfg_addr_i)
                2'd0:    off_min_d = bus.cfg_data_i;
                2'd1:    off_max_d = bus.cfg_data_i;
                2'd2:    on_min_d  = bus.cfg_data_i;
                default: on_max_d  = bus.cfg_data_i;
            endcase
        end
        err_d = (off_min_d > off_max_d) || (on_min_d > on_max_d);
    end

    // Phase sequencing: counter holds remaining cycles of the current phase
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        done_d   = done_q;
        stop_now = pend_q | bus.stop_i;
        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (bus.start_i && !bus.stop_i && !err_q) begin
                    state_d = ST_OFF;
                    cnt_d   = d_off;
                end
            end
            ST_OFF: begin
                if (stop_now) begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ON;
                    cnt_d   = d_on;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (cnt_q <= CNT_W'(1)) begin
                    done_d = (&done_q) ? done_q : done_q + DONE_W'(1);
                    pend_d = 1'b0;
                    if (stop_now) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OFF;
                        cnt_d   = d_off;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    pend_d = stop_now;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
        gate_d = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces the gate closed immediately
    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lfsr_q    <= SEED_EFF;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= '0;
            off_min_q <= CNT_W'(DEF_OFF_MIN);
            off_max_q <= CNT_W'(DEF_OFF_MAX);
            on_min_q  <= CNT_W'(DEF_ON_MIN);
            on_max_q  <= CNT_W'(DEF_ON_MAX);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            gate_q    <= gate_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            done_q    <= done_d;
            off_min_q <= off_min_d;
            off_max_q <= off_max_d;
            on_min_q  <= on_min_d;
            on_max_q  <= on_max_d;
        end
    end

    assign bus.gate_o    = gate_q;
    assign bus.busy_o    = busy_q;
    assign bus.cfg_err_o = err_q;
    assign bus.on_done_o = done_q;

endmodule

// File: tb/tb_rand_gate_scheduler.sv
// Bench for rand_gate_scheduler: phase-level reference model plus directed scenarios.
// Latency: model predicts outputs cycle by cycle; checks sampled on the falling edge.
// Backpressure: n/a; stimulus changes 1ns after the rising edge.
module tb_rand_gate_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rand_gate_scheduler_if #(.CNT_W(8), .DONE_W(16)) bus ();

    rand_gate_scheduler #(
        .CNT_W(8), .SEED(16'hACE1),
        .DEF_OFF_MIN(10), .DEF_OFF_MAX(20), .DEF_ON_MIN(30), .DEF_ON_MAX(40),
        .DONE_W(16)
    ) dut (
        .clk_i  (clk),
        .a_rst_i(rst),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase-level, integer arithmetic) ----------------
    localparam int P_IDLE = 0;
    localparam int P_OFF  = 1;
    localparam int P_ON   = 2;

    logic [15:0] m_lfsr;
    int m_cfg [4];
    int m_err, m_phase, m_left, m_pend, m_done, m_r, m_stp;

    function automatic logic [15:0] m_lfsr_step(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Length = min + floor(r*(span+1)/256); inverted window means span 0; zero becomes 1.
    function automatic int m_draw(input int mn, input int mx, input int r);
        int span, d;
        span = (mn > mx) ? 0 : mx - mn;
        d = mn + (r * (span + 1)) / 256;
        if (d == 0) d = 1;
        return d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr = 16'hACE1;
            m_cfg[0] = 10; m_cfg[1] = 20; m_cfg[2] = 30; m_cfg[3] = 40;
            m_err = 0; m_phase = P_IDLE; m_left = 0; m_pend = 0; m_done = 0;
        end else begin
            m_r   = int'(m_lfsr[7:0]);
            m_stp = int'(bus.stop_i);
            if (m_phase == P_IDLE) begin
                m_pend = 0;
                if (bus.start_i && !bus.stop_i && m_err == 0) begin
                    m_phase = P_OFF;
                    m_left  = m_draw(m_cfg[0], m_cfg[1], m_r);
                end
            end else if (m_phase == P_OFF) begin
                if (m_stp != 0 || m_pend != 0) begin
                    m_phase = P_IDLE; m_pend = 0;
                end else if (m_left == 1) begin
                    m_phase = P_ON;
                    m_left  = m_draw(m_cfg[2], m_cfg[3], m_r);
                end else begin
                    m_left--;
                end
            end else begin
                if (m_stp != 0) m_pend = 1;
                if (m_left == 1) begin
                    if (m_done < 65535) m_done++;
                    if (m_pend != 0) begin
                        m_phase = P_IDLE;
                    end else begin
                        m_phase = P_OFF;
                        m_left  = m_draw(m_cfg[0], m_cfg[1], m_r);
                    end
                    m_pend = 0;
                end else begin
                    m_left--;
                end
            end
            if (bus.cfg_we_i) m_cfg[bus.cfg_addr_i] = int'(bus.cfg_data_i);
            m_err  = (m_cfg[0] > m_cfg[1] || m_cfg[2] > m_cfg[3]) ? 1 : 0;
            m_lfsr = m_lfsr_step(m_lfsr);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_gate", int'(bus.gate_o), (m_phase == P_ON) ? 1 : 0);
            check("cyc_busy", int'(bus.busy_o), (m_phase != P_IDLE) ? 1 : 0);
            check("cyc_done", int'(bus.on_done_o), m_done);
            check("cyc_err",  int'(bus.cfg_err_o), m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = 2'(addr);
        bus.cfg_data_i = 8'(data);
        tick();
        bus.cfg_we_i   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic do_stop_and_wait(input string name);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
        end
        check(name, int'(bus.busy_o), 0);
    endtask

    task automatic wait_gate_high(input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.gate_o) break;
        end
        check(name, int'(bus.gate_o), 1);
    endtask

    logic [15:0] pat;
    int cur, run, phases, cyc;

    initial begin
        bus.cfg_we_i = 1'b0; bus.cfg_addr_i = 2'd0; bus.cfg_data_i = 8'd0;
        bus.start_i = 1'b0; bus.stop_i = 1'b0;

        // Model pins: hand-computed LFSR step and draw results
        check("pin_lfsr1", int'(m_lfsr_step(16'hACE1)), 16'hE270);
        check("pin_lfsr2", int'(m_lfsr_step(16'hE270)), 16'h7138);
        check("pin_draw_lo",  m_draw(10, 20, 0), 10);
        check("pin_draw_hi",  m_draw(10, 20, 255), 20);
        check("pin_draw_mid", m_draw(10, 20, 128), 15);
        check("pin_draw_zero", m_draw(0, 0, 200), 1);
        check("pin_draw_clamp", m_draw(5, 4, 255), 5);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gate", int'(bus.gate_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.on_done_o), 0);
        check("rst_err",  int'(bus.cfg_err_o), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // T1: fixed 3 low / 5 high pattern, two ON phases counted
        cfg_write(0, 3); cfg_write(1, 3); cfg_write(2, 5); cfg_write(3, 5);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pat[i] = bus.gate_o;
        end
        check("t1_pattern", int'(pat), 16'hF8F8);
        @(negedge clk);
        check("t1_done", int'(bus.on_done_o), 2);
        #2;
        do_stop_and_wait("t1_stop_idle");

        // T3: inverted OFF window flags error; start ignored
        tick();
        cfg_write(1, 4);
        cfg_write(0, 5);
        @(negedge clk);
        check("t3_err", int'(bus.cfg_err_o), 1);
        #2;
        pulse_start();
        repeat (3) begin
            @(negedge clk);
            check("t3_busy", int'(bus.busy_o), 0);
        end
        #2;
        cfg_write(0, 3);
        cfg_write(1, 3);
        @(negedge clk);
        check("t3_err_clr", int'(bus.cfg_err_o), 0);
        #2;

        // T4: stop on 2nd high cycle -> 3 more high cycles then idle
        pulse_start();
        wait_gate_high("t4_gate_up");
        @(posedge clk); #1;
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_tail_high", int'(bus.gate_o), 1);
        end
        @(negedge clk);
        check("t4_gate_low", int'(bus.gate_o), 0);
        check("t4_idle", int'(bus.busy_o), 0);
        #2;

        // T5: start&stop together ignored; zero OFF window gives 1-cycle OFF
        cfg_write(0, 0); cfg_write(1, 0); cfg_write(2, 2); cfg_write(3, 2);
        bus.start_i = 1'b1; bus.stop_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.stop_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t5_startstop", int'(bus.busy_o), 0);
        end
        #2;
        pulse_start();
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = bus.gate_o;
        end
        check("t5_pattern", int'(pat), 6'b110110);
        #2;
        do_stop_and_wait("t5_stop_idle");

        // T6: asynchronous reset in the middle of an ON phase
        tick();
        cfg_write(3, 5); cfg_write(2, 5);
        pulse_start();
        wait_gate_high("t6_gate_up");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t6_gate_async", int'(bus.gate_o), 0);
        check("t6_busy_async", int'(bus.busy_o), 0);
        check("t6_done_async", int'(bus.on_done_o), 0);
        check("t6_err_async",  int'(bus.cfg_err_o), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // T2: default windows (restored by reset), 1000 phases range-checked
        pulse_start();
        @(negedge clk);
        cur = int'(bus.gate_o);
        run = 1;
        phases = 0;
        cyc = 0;
        while (phases < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (int'(bus.gate_o) == cur) begin
                run++;
            end else begin
                if (cur == 0) check("t2_off_in_range", (run >= 10 && run <= 20) ? 1 : 0, 1);
                else          check("t2_on_in_range",  (run >= 30 && run <= 40) ? 1 : 0, 1);
                phases++;
                cur = int'(bus.gate_o);
                run = 1;
            end
        end
        check("t2_phase_count", phases, 1000);
        #2;
        do_stop_and_wait("t2_stop_idle");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
